// File: rtl/gol_step_ctrl.sv
// gol_step_ctrl: walks a double-banked Game-of-Life grid row by row, feeding external rule logic.
// Define GOL_STEP_CTRL_STABLE_DETECT_EN to build the still-life (stable) detector.
module gol_step_ctrl #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int RW   = $clog2(ROWS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic            step_i,
  input  logic [15:0]     period_i,
  input  logic            host_req_i,
  input  logic            host_we_i,
  input  logic [RW-1:0]   host_row_i,
  input  logic [COLS-1:0] host_wdata_i,
  output logic [COLS-1:0] host_rdata_o,
  output logic            host_ack_o,
  output logic [RW:0]     mem_addr_o,
  output logic            mem_we_o,
  output logic [COLS-1:0] mem_wdata_o,
  input  logic [COLS-1:0] mem_rdata_i,
  output logic [COLS-1:0] rule_up_o,
  output logic [COLS-1:0] rule_mid_o,
  output logic [COLS-1:0] rule_dn_o,
  input  logic [COLS-1:0] rule_next_i,
  output logic            busy_o,
  output logic            bank_o,
  output logic [15:0]     gen_count_o,
  output logic            stable_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_UP  = 3'd1,
    RD_MID = 3'd2,
    RD_DN  = 3'd3,
    CAP    = 3'd4,
    WR     = 3'd5,
    SWAP   = 3'd6
  } state_e;

  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic            bank_q, bank_d;
  logic [15:0]     gen_q, gen_d;
  logic            pending_q, pending_d;
  logic [15:0]     timer_q, timer_d;
  logic [COLS-1:0] up_q, up_d;
  logic [COLS-1:0] mid_q, mid_d;
  logic [COLS-1:0] dn_q, dn_d;
  logic            ack_q, ack_d;
  logic            start_s;
  logic            grant_s;
  logic            fire_s;

  // Free-run timer: period 0 means a trigger every cycle.
  always_comb begin
    fire_s  = 1'b0;
    timer_d = timer_q;
    if (!run_i) begin
      timer_d = 16'd0;
    end else if (period_i == 16'd0) begin
      fire_s  = 1'b1;
      timer_d = 16'd0;
    end else if (timer_q >= (period_i - 16'd1)) begin
      fire_s  = 1'b1;
      timer_d = 16'd0;
    end else begin
      timer_d = timer_q + 16'd1;
    end
  end

  // Pending request: a trigger arriving on the start cycle re-arms it.
  always_comb begin
    pending_d = (pending_q & ~start_s) | step_i | fire_s;
  end

  // Next-state, memory port and row capture.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    bank_d      = bank_q;
    gen_d       = gen_q;
    up_d        = up_q;
    mid_d       = mid_q;
    dn_d        = dn_q;
    ack_d       = 1'b0;
    start_s     = 1'b0;
    grant_s     = 1'b0;
    mem_addr_o  = {bank_q, row_q};
    mem_we_o    = 1'b0;
    mem_wdata_o = {COLS{1'b0}};
    case (state_q)
      IDLE: begin
        if (ack_q) begin
          state_d = IDLE;
        end else if (host_req_i) begin
          grant_s     = 1'b1;
          ack_d       = 1'b1;
          mem_addr_o  = {bank_q, host_row_i};
          mem_we_o    = host_we_i;
          mem_wdata_o = host_wdata_i;
        end else if (pending_q) begin
          start_s = 1'b1;
          row_d   = {RW{1'b0}};
          state_d = RD_UP;
        end else begin
          state_d = IDLE;
        end
      end
      RD_UP: begin
        mem_addr_o = {bank_q, row_q - ROW_ONE};
        state_d    = RD_MID;
      end
      RD_MID: begin
        mem_addr_o = {bank_q, row_q};
        up_d       = mem_rdata_i;
        state_d    = RD_DN;
      end
      RD_DN: begin
        mem_addr_o = {bank_q, row_q + ROW_ONE};
        mid_d      = mem_rdata_i;
        state_d    = CAP;
      end
      CAP: begin
        dn_d    = mem_rdata_i;
        state_d = WR;
      end
      WR: begin
        mem_addr_o  = {~bank_q, row_q};
        mem_we_o    = 1'b1;
        mem_wdata_o = rule_next_i;
        if (row_q == ROW_LAST) begin
          state_d = SWAP;
        end else begin
          row_d   = row_q + ROW_ONE;
          state_d = RD_UP;
        end
      end
      SWAP: begin
        bank_d  = ~bank_q;
        gen_d   = gen_q + 16'd1;
        row_d   = {RW{1'b0}};
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state registers; reset abandons any generation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      row_q     <= {RW{1'b0}};
      bank_q    <= 1'b0;
      gen_q     <= 16'd0;
      pending_q <= 1'b0;
      timer_q   <= 16'd0;
      up_q      <= {COLS{1'b0}};
      mid_q     <= {COLS{1'b0}};
      dn_q      <= {COLS{1'b0}};
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      bank_q    <= bank_d;
      gen_q     <= gen_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      up_q      <= up_d;
      mid_q     <= mid_d;
      dn_q      <= dn_d;
      ack_q     <= ack_d;
    end
  end

`ifdef GOL_STEP_CTRL_STABLE_DETECT_EN
  logic diff_q, diff_d;
  logic stable_q, stable_d;

  // Accumulate whether any written row differs from its previous contents.
  always_comb begin
    diff_d   = diff_q;
    stable_d = stable_q;
    if (start_s) begin
      diff_d = 1'b0;
    end else if ((state_q == WR) && (rule_next_i != mid_q)) begin
      diff_d = 1'b1;
    end else begin
      diff_d = diff_q;
    end
    if (state_q == SWAP) begin
      stable_d = ~diff_q;
    end else if (grant_s && host_we_i) begin
      stable_d = 1'b0;
    end else begin
      stable_d = stable_q;
    end
  end

  // Stable-detect registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      diff_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      diff_q   <= diff_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
`else
  assign stable_o = 1'b0;
`endif

  assign host_ack_o   = ack_q;
  assign host_rdata_o = mem_rdata_i;
  assign rule_up_o    = up_q;
  assign rule_mid_o   = mid_q;
  assign rule_dn_o    = dn_q;
  assign busy_o       = (state_q != IDLE);
  assign bank_o       = bank_q;
  assign gen_count_o  = gen_q;

endmodule

// File: tb/tb_gol_step_ctrl.sv
// Self-checking bench for gol_step_ctrl: bench-owned grid memory, cell-level Life reference model.
module tb_gol_step_ctrl;
  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int RW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            run, step;
  logic [15:0]     period;
  logic            host_req, host_we;
  logic [RW-1:0]   host_row;
  logic [COLS-1:0] host_wdata, host_rdata;
  logic            host_ack;
  logic [RW:0]     mem_addr;
  logic            mem_we;
  logic [COLS-1:0] mem_wdata, mem_rdata;
  logic [COLS-1:0] rule_up, rule_mid, rule_dn, rule_next;
  logic            busy, bank;
  logic [15:0]     gen_count;
  logic            stable;

  gol_step_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .step_i(step), .period_i(period),
    .host_req_i(host_req), .host_we_i(host_we), .host_row_i(host_row),
    .host_wdata_i(host_wdata), .host_rdata_o(host_rdata), .host_ack_o(host_ack),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .rule_up_o(rule_up), .rule_mid_o(rule_mid), .rule_dn_o(rule_dn), .rule_next_i(rule_next),
    .busy_o(busy), .bank_o(bank), .gen_count_o(gen_count), .stable_o(stable)
  );

  always #5 clk = ~clk;

  logic [COLS-1:0] mem [2*ROWS];
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // External rule logic (Life on three rows, columns wrap around)
  function automatic logic [COLS-1:0] rule_fn(input logic [COLS-1:0] u, input logic [COLS-1:0] m,
                                              input logic [COLS-1:0] d);
    logic [COLS-1:0] res;
    int n, l, h;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      l = (c + COLS - 1) % COLS;
      h = (c + 1) % COLS;
      n = int'(u[l]) + int'(u[c]) + int'(u[h]) + int'(m[l]) + int'(m[h])
        + int'(d[l]) + int'(d[c]) + int'(d[h]);
      res[c] = (n == 3) || (m[c] && (n == 2));
    end
    return res;
  endfunction

  always_comb rule_next = rule_fn(rule_up, rule_mid, rule_dn);

  // Reference model state
  logic [COLS-1:0] ref_g [ROWS];
  logic [COLS-1:0] exp_g [ROWS];
  logic            bank_m;
  int              gen_m;
  int              last_start;
  int              n_pass = 0;
  int              n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic compute_exp();
    int n;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              n += int'(ref_g[(r + dr + ROWS) % ROWS][(c + dc + COLS) % COLS]);
        exp_g[r][c] = (n == 3) || (ref_g[r][c] && n == 2);
      end
    end
  endtask

  task automatic load_front(input logic [COLS-1:0] g [ROWS]);
    for (int r = 0; r < ROWS; r++) begin
      ref_g[r] = g[r];
      mem[int'(bank_m) * ROWS + r] = g[r];
    end
  endtask

  task automatic step_pulse();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic idle_check(input int n);
    bit seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("no_extra_gen", seen, 1'b0);
  endtask

  task automatic host_op(input bit we, input int row, input logic [COLS-1:0] wd,
                         output logic [COLS-1:0] rd, output int lat);
    host_req = 1'b1; host_we = we; host_row = RW'(row); host_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (host_ack !== 1'b1 && lat < 300);
    chk("host_ack_seen", host_ack, 1'b1);
    rd = host_rdata;
    host_req = 1'b0; host_we = 1'b0;
    if (we) ref_g[row] = wd;
    @(negedge clk);
  endtask

  // Checks one full generation cycle by cycle, then the new front bank.
  task automatic check_gen(input int timeout, input int expect_wait, input bit host_during,
                           input int n_extra, input int hrow);
    int w, r, ph, ea;
    logic [RW:0] ea5;
    bit ew, same;
    w = 0;
    while (busy !== 1'b1 && w < timeout) begin
      @(negedge clk);
      w++;
    end
    if (busy !== 1'b1) begin
      chk("gen_start_timeout", 1'b0, 1'b1);
      return;
    end
    last_start = cyc;
    if (expect_wait >= 0) chk("gen_wait", w, expect_wait);
    compute_exp();
    for (int k = 0; k <= 5 * ROWS; k++) begin
      chk("busy_in_gen", busy, 1'b1);
      if (k < 5 * ROWS) begin
        r = k / 5; ph = k % 5; ew = 1'b0; ea = 0;
        case (ph)
          0: ea = int'(bank_m) * ROWS + (r + ROWS - 1) % ROWS;
          1: ea = int'(bank_m) * ROWS + r;
          2: ea = int'(bank_m) * ROWS + (r + 1) % ROWS;
          4: begin ea = (1 - int'(bank_m)) * ROWS + r; ew = 1'b1; end
          default: ea = 0;
        endcase
        ea5 = (RW+1)'(ea);
        if (ph == 3) chk("cap_we", mem_we, 1'b0);
        else chk($sformatf("gen_we_addr_r%0d_p%0d", r, ph), {ew, ea5}, {mem_we, mem_addr});
        if (ph == 4) begin
          chk("rule_up", rule_up, ref_g[(r + ROWS - 1) % ROWS]);
          chk("rule_mid", rule_mid, ref_g[r]);
          chk("rule_dn", rule_dn, ref_g[(r + 1) % ROWS]);
          chk($sformatf("wr_data_r%0d", r), mem_wdata, exp_g[r]);
        end
      end else begin
        chk("swap_we", mem_we, 1'b0);
      end
      if (host_during && k == 10) begin
        host_req = 1'b1; host_we = 1'b0; host_row = RW'(hrow);
      end
      step = (k >= 20) && (k < 20 + 10 * n_extra) && (k % 10 == 0);
      @(negedge clk);
    end
    same = 1'b1;
    for (int i = 0; i < ROWS; i++) begin
      if (exp_g[i] !== ref_g[i]) same = 1'b0;
      ref_g[i] = exp_g[i];
    end
    bank_m = ~bank_m;
    gen_m  = (gen_m + 1) & 16'hFFFF;
    chk("busy_after_swap", busy, 1'b0);
    chk("bank", bank, bank_m);
    chk("gen_count", gen_count, 16'(gen_m));
`ifdef GOL_STEP_CTRL_STABLE_DETECT_EN
    chk("stable", stable, same);
`else
    chk("stable_off", stable, 1'b0);
`endif
    for (int i = 0; i < ROWS; i++)
      chk($sformatf("new_front_row%0d", i), mem[int'(bank_m) * ROWS + i], ref_g[i]);
    if (host_during) begin
      chk("ack_in_grant", host_ack, 1'b0);
      @(negedge clk);
      chk("ack_after_busy", host_ack, 1'b1);
      chk("host_rdata_busy", host_rdata, ref_g[hrow]);
      host_req = 1'b0;
      @(negedge clk);
    end
  endtask

  typedef struct {
    bit              we;
    int              row;
    logic [COLS-1:0] wd;
    logic [COLS-1:0] exp;
  } hv_t;

  hv_t             tbl [8];
  logic [COLS-1:0] g [ROWS];
  logic [COLS-1:0] rd;
  int              lat, t0, t1, t2;

  initial begin
    tbl[0] = '{1'b1, 2,  16'hA5A5, 16'h0000};
    tbl[1] = '{1'b1, 3,  16'h1234, 16'h0000};
    tbl[2] = '{1'b1, 15, 16'hFFFF, 16'h0000};
    tbl[3] = '{1'b0, 2,  16'h0000, 16'hA5A5};
    tbl[4] = '{1'b0, 3,  16'h0000, 16'h1234};
    tbl[5] = '{1'b0, 15, 16'h0000, 16'hFFFF};
    tbl[6] = '{1'b1, 3,  16'h0F0F, 16'h0000};
    tbl[7] = '{1'b0, 3,  16'h0000, 16'h0F0F};

    for (int i = 0; i < 2 * ROWS; i++) mem[i] = '0;
    for (int i = 0; i < ROWS; i++) ref_g[i] = '0;
    bank_m = 1'b0; gen_m = 0; last_start = 0;
    rst = 1'b1; run = 1'b0; step = 1'b0; period = 16'd0;
    host_req = 1'b0; host_we = 1'b0; host_row = '0; host_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bank", bank, 1'b0);
    chk("rst_gen", gen_count, 16'd0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_ack", host_ack, 1'b0);
    chk("rst_stable", stable, 1'b0);
    chk("rst_rules", {rule_up, rule_mid, rule_dn}, 48'd0);
    rst = 1'b0;
    @(negedge clk);

    // Host access table
    for (int i = 0; i < 8; i++) begin
      host_op(tbl[i].we, tbl[i].row, tbl[i].wd, rd, lat);
      chk("host_lat", lat, 1);
      if (!tbl[i].we) chk($sformatf("host_rd_%0d", i), rd, tbl[i].exp);
    end

    // Back-to-back requests: no grant in the ack cycle
    host_req = 1'b1; host_we = 1'b0; host_row = RW'(2);
    @(negedge clk);
    chk("b2b_ack1", host_ack, 1'b1);
    chk("b2b_rd1", host_rdata, 16'hA5A5);
    host_row = RW'(15);
    @(negedge clk);
    chk("b2b_no_ack", host_ack, 1'b0);
    @(negedge clk);
    chk("b2b_ack2", host_ack, 1'b1);
    chk("b2b_rd2", host_rdata, 16'hFFFF);
    host_req = 1'b0;
    @(negedge clk);

    // Blinker
    for (int r = 0; r < ROWS; r++) begin
      host_op(1'b1, r, (r >= 7 && r <= 9) ? 16'h0100 : 16'h0000, rd, lat);
    end
    step_pulse();
    check_gen(10, 1, 1'b0, 0, 0);
    chk("blinker_row8", mem[ROWS + 8], 16'h0380);
    chk("blinker_row7", mem[ROWS + 7], 16'h0000);
    chk("blinker_row9", mem[ROWS + 9], 16'h0000);
    chk("blinker_bank", bank, 1'b1);
    chk("blinker_gen", gen_count, 16'd1);

    // Toroidal row wrap
    for (int r = 0; r < ROWS; r++) g[r] = (r == 0 || r == ROWS - 1) ? 16'h0001 : 16'h0000;
    load_front(g);
    step_pulse();
    check_gen(10, 1, 1'b0, 0, 0);

    // Host request and step together in IDLE
    host_req = 1'b1; host_we = 1'b1; host_row = RW'(5); host_wdata = 16'h7000; step = 1'b1;
    @(negedge clk);
    chk("cont_ack", host_ack, 1'b1);
    chk("cont_busy", busy, 1'b0);
    host_req = 1'b0; host_we = 1'b0; step = 1'b0;
    ref_g[5] = 16'h7000;
    check_gen(10, 2, 1'b0, 0, 0);

    // Host request while busy
    for (int r = 0; r < ROWS; r++) g[r] = 16'($urandom);
    load_front(g);
    step_pulse();
    check_gen(10, 1, 1'b1, 0, 3);

    // Still life block, then a host write
    for (int r = 0; r < ROWS; r++) g[r] = (r == 4 || r == 5) ? 16'h0018 : 16'h0000;
    load_front(g);
    step_pulse();
    check_gen(10, 1, 1'b0, 0, 0);
    host_op(1'b1, 0, 16'h0000, rd, lat);
    chk("stable_after_wr", stable, 1'b0);

    // Random grids, with extra step pulses during a generation
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < ROWS; r++) g[r] = 16'($urandom) & 16'($urandom);
      load_front(g);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      step_pulse();
      check_gen(10, 1, 1'b0, it % 4, 0);
      if (it % 4 != 0) check_gen(10, 1, 1'b0, 0, 0);
      idle_check(15);
    end

    // Free-run with period 100
    period = 16'd100; run = 1'b1;
    check_gen(150, -1, 1'b0, 0, 0); t0 = last_start;
    check_gen(150, -1, 1'b0, 0, 0); t1 = last_start;
    check_gen(150, -1, 1'b0, 0, 0); t2 = last_start;
    chk("period_gap1", t1 - t0, 100);
    chk("period_gap2", t2 - t1, 100);
    run = 1'b0;
    idle_check(150);

    // Free-run with period 0: back-to-back generations
    period = 16'd0; run = 1'b1;
    check_gen(10, 2, 1'b0, 0, 0);
    check_gen(10, 1, 1'b0, 0, 0);
    run = 1'b0;
    check_gen(10, 1, 1'b0, 0, 0);
    idle_check(50);

    // Reset mid-generation (RD_DN of row 5)
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bank_m = 1'b0; gen_m = 0;
    for (int r = 0; r < ROWS; r++) g[r] = 16'($urandom) | 16'h0100;
    load_front(g);
    step_pulse();
    lat = 0;
    while (busy !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("abort_gen_started", busy, 1'b1);
    repeat (27) @(negedge clk);
    chk("abort_rd_dn_addr", {mem_we, mem_addr}, {1'b0, 5'd6});
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_bank", bank, 1'b0);
    chk("abort_gen", gen_count, 16'd0);
    chk("abort_we", mem_we, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_check(10);
    step_pulse();
    check_gen(10, 1, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
